// File: rtl/env_pkg.sv
// Shared envelope definitions: state encoding and level limits for the
// ADSR generator and anything downstream that interprets envelope levels.
package env_pkg;

  localparam int ENV_WIDTH = 16;
  localparam logic [ENV_WIDTH-1:0] ENV_MAX = {ENV_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } env_state;

endpackage

// File: rtl/env_scaler.sv
// Registered unsigned sample x level multiply, keeping the top WIDTH bits of
// the full product (truncation, no rounding). Also usable in the voice mixer.
module env_scaler #(
  parameter int WIDTH     = 24,
  parameter int ENV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     sample,
  input  logic [ENV_WIDTH-1:0] level,
  output logic [WIDTH-1:0]     scaled
);

  logic [WIDTH+ENV_WIDTH-1:0] prod_p0;
  logic [WIDTH-1:0]           scaled_p1;

  assign prod_p0 = {{ENV_WIDTH{1'b0}}, sample} * {{WIDTH{1'b0}}, level};

  // stage p0 -> p1: product registered, upper WIDTH bits kept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scaled_p1 <= '0;
    end else begin
      scaled_p1 <= WIDTH'(prod_p0 >> ENV_WIDTH);
    end
  end

  assign scaled = scaled_p1;

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope: state machine and level arithmetic, driving a
// registered scaler that applies the current level to the oscillator stream.
module adsr_envelope #(
  parameter int WIDTH     = 24,
  parameter int ENV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 gate,
  input  logic                 trig,
  input  logic [ENV_WIDTH-1:0] attack_step,
  input  logic [ENV_WIDTH-1:0] decay_step,
  input  logic [ENV_WIDTH-1:0] sustain_level,
  input  logic [ENV_WIDTH-1:0] release_step,
  input  logic [WIDTH-1:0]     in,
  output logic [WIDTH-1:0]     out,
  output logic [ENV_WIDTH-1:0] env_level,
  output logic                 active
);

  import env_pkg::*;

  localparam logic [ENV_WIDTH-1:0] LEVEL_MAX = {ENV_WIDTH{1'b1}};

  env_state               state_p0, state_d;
  logic [ENV_WIDTH-1:0]   level_p0, level_d;
  logic                   active_p0, active_d;

  // Sum widened by one bit so a near-full level never wraps past the top.
  function automatic logic attack_sat(input logic [ENV_WIDTH-1:0] lvl,
                                      input logic [ENV_WIDTH-1:0] step);
    logic [ENV_WIDTH:0] sum;
    sum = {1'b0, lvl} + {1'b0, step};
    return (step == '0) || (sum >= {1'b0, LEVEL_MAX});
  endfunction

  function automatic logic decay_sat(input logic [ENV_WIDTH-1:0] lvl,
                                     input logic [ENV_WIDTH-1:0] step,
                                     input logic [ENV_WIDTH-1:0] floor_lvl);
    logic signed [ENV_WIDTH:0] diff;
    diff = $signed({1'b0, lvl}) - $signed({1'b0, step});
    return (step == '0) || (diff <= $signed({1'b0, floor_lvl}));
  endfunction

  function automatic logic release_sat(input logic [ENV_WIDTH-1:0] lvl,
                                       input logic [ENV_WIDTH-1:0] step);
    return (step == '0) || (lvl <= step);
  endfunction

  // stage p0: state, level and active flag move together on one edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_p0  <= IDLE;
      level_p0  <= '0;
      active_p0 <= 1'b0;
    end else begin
      state_p0  <= state_d;
      level_p0  <= level_d;
      active_p0 <= active_d;
    end
  end

  always_comb begin
    state_d = state_p0;
    level_d = level_p0;
    if (!gate && (state_p0 != IDLE) && (state_p0 != RELEASE)) begin
      state_d = RELEASE;
    end else if (gate && trig) begin
      state_d = ATTACK;
    end else begin
      case (state_p0)
        IDLE: begin
          level_d = '0;
          if (gate) state_d = ATTACK;
        end
        ATTACK: begin
          if (attack_sat(level_p0, attack_step)) begin
            level_d = LEVEL_MAX;
            state_d = DECAY;
          end else begin
            level_d = level_p0 + attack_step;
          end
        end
        DECAY: begin
          if (decay_sat(level_p0, decay_step, sustain_level)) begin
            level_d = sustain_level;
            state_d = SUSTAIN;
          end else begin
            level_d = level_p0 - decay_step;
          end
        end
        SUSTAIN: begin
          level_d = sustain_level;
        end
        RELEASE: begin
          if (gate) begin
            state_d = ATTACK;
          end else if (release_sat(level_p0, release_step)) begin
            level_d = '0;
            state_d = IDLE;
          end else begin
            level_d = level_p0 - release_step;
          end
        end
        default: begin
          state_d = IDLE;
          level_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    active_d = (state_d != IDLE);
  end

  // stage p0 -> p1: scaling uses the level held before this edge's update
  env_scaler #(
    .WIDTH     (WIDTH),
    .ENV_WIDTH (ENV_WIDTH)
  ) u_scaler (
    .clk    (clk),
    .rstn   (rstn),
    .sample (in),
    .level  (level_p0),
    .scaled (out)
  );

  assign env_level = level_p0;
  assign active    = active_p0;

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: a cycle model pushes expected
// level/active/out per edge to a scoreboard queue, popped after each edge.
module tb_adsr_envelope;

  localparam int W  = 24;
  localparam int EW = 16;

  localparam int M_IDLE = 0;
  localparam int M_ATK  = 1;
  localparam int M_DEC  = 2;
  localparam int M_SUS  = 3;
  localparam int M_REL  = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          gate = 1'b0;
  logic          trig = 1'b0;
  logic [EW-1:0] attack_step = '0;
  logic [EW-1:0] decay_step = '0;
  logic [EW-1:0] sustain_level = '0;
  logic [EW-1:0] release_step = '0;
  logic [W-1:0]  in_s = '0;
  logic [W-1:0]  out_s;
  logic [EW-1:0] env_level;
  logic          active;

  typedef struct packed {
    logic [EW-1:0] lvl;
    logic          act;
    logic [W-1:0]  o;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  int m_st  = M_IDLE;
  int m_lvl = 0;

  adsr_envelope #(.WIDTH(W), .ENV_WIDTH(EW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .gate          (gate),
    .trig          (trig),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .in            (in_s),
    .out           (out_s),
    .env_level     (env_level),
    .active        (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_step();
    longint prod;
    exp_t   e;
    int a, d, s, r;
    a = int'(attack_step);
    d = int'(decay_step);
    s = int'(sustain_level);
    r = int'(release_step);
    prod = longint'(in_s) * longint'(m_lvl);
    e.o  = W'(prod / 65536);
    if (!gate && m_st != M_IDLE && m_st != M_REL) begin
      m_st = M_REL;
    end else if (gate && trig) begin
      m_st = M_ATK;
    end else begin
      case (m_st)
        M_IDLE: begin
          m_lvl = 0;
          if (gate) m_st = M_ATK;
        end
        M_ATK: begin
          if (a == 0 || m_lvl + a >= 65535) begin m_lvl = 65535; m_st = M_DEC; end
          else m_lvl = m_lvl + a;
        end
        M_DEC: begin
          if (d == 0 || m_lvl - d <= s) begin m_lvl = s; m_st = M_SUS; end
          else m_lvl = m_lvl - d;
        end
        M_SUS: m_lvl = s;
        default: begin
          if (gate) m_st = M_ATK;
          else if (r == 0 || m_lvl <= r) begin m_lvl = 0; m_st = M_IDLE; end
          else m_lvl = m_lvl - r;
        end
      endcase
    end
    e.lvl = EW'(m_lvl);
    e.act = (m_st != M_IDLE);
    sb_q.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, "_lvl"}, 64'(env_level), 64'(e.lvl));
    chk({tag, "_act"}, 64'(active), 64'(e.act));
    chk({tag, "_out"}, 64'(out_s), 64'(e.o));
  endtask

  initial begin
    logic [EW-1:0] seq_ad [9];
    logic [EW-1:0] seq_rel [4];
    seq_ad  = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF,
                16'hEFFF, 16'hDFFF, 16'hCFFF, 16'hC000};
    seq_rel = '{16'hC000, 16'h7000, 16'h2000, 16'h0000};

    attack_step   = 16'h4000;
    decay_step    = 16'h1000;
    sustain_level = 16'hC000;
    release_step  = 16'h5000;
    in_s          = 24'h800000;

    #12;
    chk("rst_lvl", 64'(env_level), 64'd0);
    chk("rst_act", 64'(active), 64'd0);
    chk("rst_out", 64'(out_s), 64'd0);
    rstn = 1'b1;

    // attack ramp and decay to sustain
    gate = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step("ad");
      chk("tp_ad_lvl", 64'(env_level), 64'(seq_ad[i]));
      if (i == 1) chk("tp_scale_zero", 64'(out_s), 64'd0);
      if (i == 3) chk("tp_scale_half", 64'(out_s), 64'h400000);
    end
    step("sus");
    chk("tp_sus_lvl", 64'(env_level), 64'hC000);

    // release to idle
    gate = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("rel");
      chk("tp_rel_lvl", 64'(env_level), 64'(seq_rel[i]));
    end
    chk("tp_idle_act", 64'(active), 64'd0);
    step("idle");
    chk("tp_idle_out", 64'(out_s), 64'd0);

    // retrigger during release
    gate = 1'b1;
    for (int k = 0; k < 40 && m_st != M_SUS; k++) step("to_sus");
    gate = 1'b0;
    step("rel2");
    step("rel2");
    chk("tp_rel_7000", 64'(env_level), 64'h7000);
    gate = 1'b1;
    step("retrig");
    chk("tp_retrig_lvl", 64'(env_level), 64'h7000);
    chk("tp_retrig_act", 64'(active), 64'd1);
    step("retrig");
    chk("tp_retrig_next", 64'(env_level), 64'hB000);
    for (int k = 0; k < 40 && m_st != M_SUS; k++) step("to_sus");

    // trig pulse in sustain
    trig = 1'b1;
    step("trig");
    chk("tp_trig_lvl", 64'(env_level), 64'hC000);
    trig = 1'b0;
    step("trig");
    chk("tp_trig_next", 64'(env_level), 64'hFFFF);
    for (int k = 0; k < 40 && m_st != M_SUS; k++) step("to_sus");

    // trig with gate low is ignored
    gate = 1'b0;
    for (int k = 0; k < 40 && m_st != M_IDLE; k++) step("to_idle");
    trig = 1'b1;
    step("trig_nogate");
    chk("tp_trig_nogate", 64'(active), 64'd0);
    trig = 1'b0;

    // instant steps
    attack_step   = 16'h0000;
    decay_step    = 16'h0000;
    release_step  = 16'h0000;
    sustain_level = 16'h1234;
    gate = 1'b1;
    step("inst");
    step("inst");
    chk("tp_inst_max", 64'(env_level), 64'hFFFF);
    step("inst");
    chk("tp_inst_sus", 64'(env_level), 64'h1234);
    step("inst");
    gate = 1'b0;
    step("inst");
    chk("tp_inst_rel", 64'(env_level), 64'h1234);
    step("inst");
    chk("tp_inst_idle_lvl", 64'(env_level), 64'd0);
    chk("tp_inst_idle_act", 64'(active), 64'd0);

    // asynchronous reset in decay
    attack_step   = 16'h4000;
    decay_step    = 16'h0100;
    sustain_level = 16'h1000;
    gate = 1'b1;
    for (int k = 0; k < 40 && m_st != M_DEC; k++) step("to_dec");
    step("dec");
    step("dec");
    #2;
    rstn = 1'b0;
    #1;
    chk("tp_arst_lvl", 64'(env_level), 64'd0);
    chk("tp_arst_act", 64'(active), 64'd0);
    chk("tp_arst_out", 64'(out_s), 64'd0);
    @(posedge clk);
    #1;
    rstn  = 1'b1;
    m_st  = M_IDLE;
    m_lvl = 0;
    gate  = 1'b0;
    step("post_rst");
    chk("tp_post_rst_act", 64'(active), 64'd0);
    gate = 1'b1;
    step("post_rst");
    chk("tp_post_rst_lvl", 64'(env_level), 64'd0);

    // randomised traffic through the scoreboard
    for (int n = 0; n < 400; n++) begin
      gate          = ($urandom_range(0, 15) != 0);
      trig          = ($urandom_range(0, 31) == 0);
      in_s          = W'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        attack_step   = EW'($urandom_range(0, 16'h3000));
        decay_step    = EW'($urandom_range(0, 16'h3000));
        release_step  = EW'($urandom_range(0, 16'h3000));
        sustain_level = EW'($urandom);
      end
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
